// File: rtl/reduccion_signo.sv
// Store-path narrowing: truncates a register value to byte/half/word, replicates it
// across byte lanes, builds byte enables and performs a bounded req/ack memory write.
module reduccion_signo #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [1:0]        in_size,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              done,
  output logic              ovf,
  output logic [1:0]        err
);

  typedef enum logic [1:0] {StIdle, StReq, StFin} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        err_q, err_d;

  logic [31:0] f_wdata;
  logic [3:0]  f_be;
  logic        f_ovf;
  logic        f_bad;

  // Narrowed fields for the request currently presented at the input
  always_comb begin
    f_wdata = in_data;
    f_be    = 4'b1111;
    f_ovf   = 1'b0;
    f_bad   = 1'b0;
    case (in_size)
      2'b00: begin
        f_wdata = {4{in_data[7:0]}};
        f_be    = 4'b0001 << in_addr[1:0];
        f_ovf   = !((&in_data[31:7]) || !(|in_data[31:7]));
      end
      2'b01: begin
        f_wdata = {2{in_data[15:0]}};
        f_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        f_ovf   = !((&in_data[31:15]) || !(|in_data[31:15]));
        f_bad   = in_addr[0];
      end
      2'b10: begin
        f_bad = |in_addr[1:0];
      end
      default: begin
        f_bad = 1'b1;
      end
    endcase
    if (f_bad) begin
      f_be  = 4'b0000;
      f_ovf = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
          wdata_d = f_wdata;
          be_d    = f_be;
          ovf_d   = f_ovf;
          cnt_d   = 8'd0;
          if (f_bad) begin
            err_d   = 2'b01;
            done_d  = 1'b1;
            state_d = StFin;
          end else begin
            err_d   = 2'b00;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // Ack has priority so an ack on the final allowed cycle still succeeds
        if (mem_ack) begin
          err_d   = 2'b00;
          done_d  = 1'b1;
          state_d = StFin;
        end else if (cnt_q == CntLast) begin
          err_d   = 2'b10;
          done_d  = 1'b1;
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StFin: begin
        cnt_d   = 8'd0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign mem_req   = (state_q == StReq);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reduccion_signo.sv
// Bench for reduccion_signo: table of store vectors with a scoreboard queue, plus
// hand sequences for reset mid-request and back-to-back acceptance.
module tb_reduccion_signo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] in_addr;
  logic [1:0]  in_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        ovf;
  logic [1:0]  err;

  int errors = 0;
  int checks = 0;

  reduccion_signo #(
    .TIMEOUT(4),
    .ADDR_W (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .in_size  (in_size),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .done     (done),
    .ovf      (ovf),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  size;
    int          ack_dly;   // REQ cycles before ack; large means never
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ovf;
    logic [1:0]  err;
    int          req_cyc;
  } vec_t;

  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_store(input vec_t v);
    int   nreq;
    bit   got;
    vec_t e;
    @(negedge clk);
    chk("idle ready", 32'(in_ready), 32'd1);
    chk("done one cycle", 32'(done), 32'd0);
    in_data  = v.data;
    in_addr  = v.addr;
    in_size  = v.size;
    in_valid = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    nreq = 0;
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (mem_req) begin
        chk("mem_addr", mem_addr, v.maddr);
        chk("mem_wdata", mem_wdata, v.wdata);
        chk("mem_be req", 32'(mem_be), 32'(v.be));
        nreq++;
        mem_ack = (nreq == v.ack_dly + 1);
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        e = sb.pop_front();
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("err", 32'(err), 32'(e.err));
        chk("req cycles", nreq, e.req_cyc);
        chk("mem_be done", 32'(mem_be), 32'(e.be));
        got = 1'b1;
      end
      if (!got) @(negedge clk);
    end
    mem_ack = 1'b0;
    if (!got) chk("done wait", 32'd0, 32'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int acc[2];
    int n_acc;
    int ndone;
    int nreq;
    bit saw;

    vecs[0] = '{32'hFFFFFF80, 32'h102, 2'b00, 2,    32'h100, 32'h80808080, 4'b0100, 1'b0, 2'b00, 3};
    vecs[1] = '{32'h00012345, 32'h206, 2'b01, 0,    32'h204, 32'h23452345, 4'b1100, 1'b1, 2'b00, 1};
    vecs[2] = '{32'h11223344, 32'h301, 2'b10, 0,    32'h300, 32'h11223344, 4'b0000, 1'b0, 2'b01, 0};
    vecs[3] = '{32'hDEADBEEF, 32'h400, 2'b10, 1000, 32'h400, 32'hDEADBEEF, 4'b1111, 1'b0, 2'b10, 4};
    vecs[4] = '{32'hDEADBEEF, 32'h404, 2'b10, 3,    32'h404, 32'hDEADBEEF, 4'b1111, 1'b0, 2'b00, 4};
    vecs[5] = '{32'h00000001, 32'h500, 2'b11, 0,    32'h500, 32'h00000001, 4'b0000, 1'b0, 2'b01, 0};
    vecs[6] = '{32'h00000080, 32'h003, 2'b00, 0,    32'h000, 32'h80808080, 4'b1000, 1'b1, 2'b00, 1};
    vecs[7] = '{32'hFFFF8000, 32'h010, 2'b01, 0,    32'h010, 32'h80008000, 4'b0011, 1'b0, 2'b00, 1};
    vecs[8] = '{32'h00001234, 32'h011, 2'b01, 0,    32'h010, 32'h12341234, 4'b0000, 1'b0, 2'b01, 0};
    vecs[9] = '{32'h0000007F, 32'h001, 2'b00, 1,    32'h000, 32'h7F7F7F7F, 4'b0010, 1'b0, 2'b00, 2};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 32'd0;
    in_addr  = 32'd0;
    in_size  = 2'b00;
    mem_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ovf", 32'(ovf), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) do_store(vecs[i]);

    // Reset while a word store is waiting for ack
    @(negedge clk);
    in_data  = 32'hCAFEF00D;
    in_addr  = 32'h600;
    in_size  = 2'b10;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-rst mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst async mem_req", 32'(mem_req), 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd1);
    saw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw = 1'b1;
    end
    chk("no done after abort", 32'(saw), 32'd0);
    do_store(vecs[9]);

    // Back-to-back with ack held high throughout
    @(negedge clk);
    in_data  = 32'h00000011;
    in_addr  = 32'h700;
    in_size  = 2'b00;
    in_valid = 1'b1;
    mem_ack  = 1'b1;
    n_acc = 0;
    ndone = 0;
    nreq  = 0;
    acc[0] = 0;
    acc[1] = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready && in_valid && n_acc < 2) begin
        acc[n_acc] = i;
        n_acc++;
      end else if (n_acc == 2) begin
        in_valid = 1'b0;
      end
      if (done) ndone++;
      if (mem_req) nreq++;
      @(negedge clk);
    end
    mem_ack  = 1'b0;
    in_valid = 1'b0;
    chk("b2b accepts", n_acc, 2);
    chk("b2b spacing", acc[1] - acc[0], 3);
    chk("b2b dones", ndone, 2);
    chk("b2b req cycles", nreq, 2);
    chk("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reduccion_signo.md
Name: reduccion_signo

Overview:
- Store-path narrowing unit for the single-cycle datapath; the inverse of the immediate/load sign-extension path.
- Accepts a 32-bit register value with a target size (byte/half/word) and an address.
- Truncates the value to the narrow field, replicates it across byte lanes, and generates byte enables.
- Drives a request/acknowledge write to data memory with a bounded wait.
- Flags values that are not representable as a sign-extended narrow field (overflow), misaligned addresses and bad sizes.

Parameters:
TIMEOUT, 16, max cycles in REQ waiting for mem_ack before abort (1..255)
ADDR_W, 32, address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  store request valid
in_ready  output  1  unit idle, can accept
in_data  input  32  register value to store
in_addr  input  ADDR_W  byte address
in_size  input  2  00 byte, 01 half, 10 word, 11 reserved
mem_req  output  1  write request to data memory
mem_addr  output  ADDR_W  word-aligned address ({in_addr[ADDR_W-1:2],2'b00})
mem_wdata  output  32  lane-replicated write data
mem_be  output  4  byte enables
mem_ack  input  1  memory write accepted (one-cycle pulse)
done  output  1  one-cycle pulse: transaction finished (success or error)
ovf  output  1  valid with done: value not representable in narrow size
err  output  2  valid with done: 00 ok, 01 misaligned/bad size, 10 timeout

Behaviour:
- Reset (async, any state): FSM to IDLE; in_ready=1; mem_req=0; mem_addr=0; mem_wdata=0; mem_be=0; done=0; ovf=0; err=00; timeout counter=0. mem_req deasserts immediately, mid-transaction included; no done is issued for an aborted transaction.
- States: IDLE, REQ, FIN.
- IDLE: in_ready=1. Accept on in_valid at the clock edge and register data, address, size and the computed fields.
  - If size==11, or half with in_addr[0]=1, or word with in_addr[1:0]!=0: go to FIN with err=01, mem_be=0, and no mem_req.
  - Otherwise go to REQ.
- Field computation (registered at accept):
  - Byte: wdata={4{in_data[7:0]}}; be=4'b0001<<in_addr[1:0]; ovf = in_data[31:7] not all-equal.
  - Half: wdata={2{in_data[15:0]}}; be = in_addr[1] ? 4'b1100 : 4'b0011; ovf = in_data[31:15] not all-equal.
  - Word: wdata=in_data; be=4'b1111; ovf=0.
  - ovf does not block the write: the truncated value is still stored.
- REQ: mem_req=1. mem_addr, mem_wdata and mem_be are held stable for the whole request.
  - Counter increments each cycle without mem_ack.
  - mem_ack=1 → FIN with err=00. Ack is checked before timeout, so an ack on the last allowed cycle wins.
  - Counter reaches TIMEOUT-1 without ack → FIN with err=10.
  - mem_ack while not in REQ is ignored.
- FIN: exactly one cycle. done=1; ovf and err valid; mem_req=0; in_ready=0. Next state is IDLE, and the counter clears.
- done, ovf and err are registered outputs. ovf and err hold their last values until the next acceptance; done is high for the FIN cycle only.
- Latency:
  - Accept edge to mem_req=1 is 1 cycle.
  - mem_ack edge to done=1 is 1 cycle.
  - Minimum accept-to-accept spacing is 3 cycles (IDLE→REQ→FIN→IDLE) with same-cycle ack.
- in_valid while in_ready=0 is ignored; no queueing.

Test Plan:
- Byte store: in_data=0xFFFFFF80, in_size=00, in_addr=0x102, ack after 2 cycles → mem_addr=0x100, mem_wdata=0x80808080, mem_be=0100; done pulse with ovf=0, err=00.
- Half store with overflow: in_data=0x00012345, in_size=01, in_addr=0x206, immediate ack → mem_wdata=0x23452345, mem_be=1100, ovf=1, err=00; the write still occurs.
- Misaligned: in_size=10, in_addr=0x301 → mem_req never asserts; done one cycle after accept with err=01, ovf=0.
- Timeout: TIMEOUT=4, word store, mem_ack held 0 → mem_req high for exactly 4 cycles, then done with err=10. A mem_ack arriving on the 4th REQ cycle instead yields err=00.
- Reset mid-request: assert rst during REQ → mem_req drops before the next edge, with no done. After release, in_ready=1 and a new byte store completes normally.
- Back-to-back: two stores presented continuously with same-cycle ack → accepts spaced exactly 3 cycles apart; in_valid during REQ/FIN is ignored.
